// File: rtl/pw_seq_pkg.sv
// Shared types for the pointwise stream sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a. PW_SEQ_PINGPONG_EN selects two buffer banks instead of one.
package pw_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef PW_SEQ_PINGPONG_EN
    localparam int NUM_BANKS = 2;
`else
    localparam int NUM_BANKS = 1;
`endif

endpackage

// File: rtl/pw_seq_bank.sv
// One pixel's activation vector: DEPTH x DATA_W storage.
// Latency: write lands on the clock edge; read is combinational.
// Backpressure: none; the owner gates writes and reads.
module pw_seq_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic signed [DATA_W-1:0] wdata,
    input  logic [AW-1:0]            raddr,
    output logic signed [DATA_W-1:0] rdata
);

    logic signed [DATA_W-1:0] mem [DEPTH];

    // Synchronous write port; contents are not reset (full flags guard reads)
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pw_stream_sequencer.sv
// Buffers one pixel's depthwise channel vector and replays it once per output channel.
// Latency: first out beat the cycle after a pixel's last input beat; 1 beat/cycle each side.
// Backpressure: in_ready drops while the write bank is full; out_* hold while !out_ready. Macro: PW_SEQ_PINGPONG_EN.
module pw_stream_sequencer
    import pw_seq_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_C_IN  = 1024,
    parameter int MAX_C_OUT = 1024,
    parameter int MAX_PIX   = 12544,
    parameter int CI_W      = $clog2(MAX_C_IN + 1),
    parameter int CO_W      = $clog2(MAX_C_OUT + 1),
    parameter int PIX_W     = $clog2(MAX_PIX + 1),
    parameter int WA_W      = $clog2(MAX_C_IN * MAX_C_OUT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CI_W-1:0]          cfg_c_in,
    input  logic [CO_W-1:0]          cfg_c_out,
    input  logic [PIX_W-1:0]         cfg_num_pix,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_first_in_ch,
    output logic                     out_last_in_ch,
    output logic [CO_W-1:0]          out_oc,
    output logic [WA_W-1:0]          out_w_addr,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(MAX_C_IN);

    state_t state, state_nxt;

    logic [CI_W-1:0]  c_in, wr_idx, ic;
    logic [CO_W-1:0]  c_out, oc;
    logic [PIX_W-1:0] num_pix, pix_in, pix_out;
    logic [WA_W-1:0]  w_addr;
    logic             first_q, last_q;
    logic             wr_bank, rd_bank, wr_full, rd_full;
    logic [NUM_BANKS-1:0] full;
    logic [NUM_BANKS-1:0] bank_we;
    logic signed [DATA_W-1:0] bank_rd [NUM_BANKS];
    logic signed [DATA_W-1:0] rd_data;
    logic start_acc, cfg_zero, in_fire, out_fire;
    logic wr_last, ic_last, oc_last, pix_end, layer_end;

    assign start_acc = (state == IDLE) && start;
    assign cfg_zero  = (cfg_c_in == '0) || (cfg_c_out == '0) || (cfg_num_pix == '0);
    assign in_ready  = (state == RUN) && !wr_full && (pix_in < num_pix);
    assign out_valid = (state == RUN) && rd_full;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign wr_last   = (wr_idx == c_in - CI_W'(1));
    assign ic_last   = (ic == c_in - CI_W'(1));
    assign oc_last   = (oc == c_out - CO_W'(1));
    assign pix_end   = out_fire && ic_last && oc_last;
    assign layer_end = pix_end && (pix_out == num_pix - PIX_W'(1));

`ifdef PW_SEQ_PINGPONG_EN
    // Ping-pong bank pointers: each side flips after finishing a pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else if (start_acc) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            if (in_fire && wr_last) wr_bank <= ~wr_bank;
            if (pix_end)            rd_bank <= ~rd_bank;
        end
    end
    assign wr_full = full[wr_bank];
    assign rd_full = full[rd_bank];
    assign rd_data = bank_rd[rd_bank];
`else
    assign wr_bank = 1'b0;
    assign rd_bank = 1'b0;
    assign wr_full = full[0];
    assign rd_full = full[0];
    assign rd_data = bank_rd[0];
`endif

    // Zero the data bus whenever no beat is offered so idle/reset values are defined
    assign out_data = out_valid ? rd_data : '0;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign bank_we[b] = in_fire && (wr_bank == 1'(b));

        // Full flag: set by the last fill beat, cleared by the last drain beat of the pixel
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                full[b] <= 1'b0;
            end else if (start_acc) begin
                full[b] <= 1'b0;
            end else if (in_fire && wr_last && (wr_bank == 1'(b))) begin
                full[b] <= 1'b1;
            end else if (pix_end && (rd_bank == 1'(b))) begin
                full[b] <= 1'b0;
            end
        end

        pw_seq_bank #(.DATA_W(DATA_W), .DEPTH(MAX_C_IN), .AW(AW)) u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .waddr (wr_idx[AW-1:0]),
            .wdata (in_data),
            .raddr (ic[AW-1:0]),
            .rdata (bank_rd[b])
        );
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state: zero-sized layers skip straight to DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = cfg_zero ? DONE : RUN;
            RUN:     if (layer_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state == RUN) || (state == DONE);
        done = (state == DONE);
    end

    // Layer configuration, captured only on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_in    <= '0;
            c_out   <= '0;
            num_pix <= '0;
        end else if (start_acc) begin
            c_in    <= cfg_c_in;
            c_out   <= cfg_c_out;
            num_pix <= cfg_num_pix;
        end
    end

    // Fill side: channel index within the pixel and pixels written so far
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= '0;
            pix_in <= '0;
        end else if (start_acc) begin
            wr_idx <= '0;
            pix_in <= '0;
        end else if (in_fire) begin
            if (wr_last) begin
                wr_idx <= '0;
                pix_in <= pix_in + PIX_W'(1);
            end else begin
                wr_idx <= wr_idx + CI_W'(1);
            end
        end
    end

    // Drain side: ic/oc walk plus registered sideband; w_addr runs instead of oc*c_in+ic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ic      <= '0;
            oc      <= '0;
            pix_out <= '0;
            w_addr  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (start_acc) begin
            ic      <= '0;
            oc      <= '0;
            pix_out <= '0;
            w_addr  <= '0;
            first_q <= 1'b1;
            last_q  <= (cfg_c_in == CI_W'(1));
        end else if (out_fire) begin
            if (ic_last) begin
                ic      <= '0;
                first_q <= 1'b1;
                last_q  <= (c_in == CI_W'(1));
                if (oc_last) begin
                    oc      <= '0;
                    w_addr  <= '0;
                    pix_out <= pix_out + PIX_W'(1);
                end else begin
                    oc     <= oc + CO_W'(1);
                    w_addr <= w_addr + WA_W'(1);
                end
            end else begin
                ic      <= ic + CI_W'(1);
                first_q <= 1'b0;
                last_q  <= (ic + CI_W'(2) == c_in);
                w_addr  <= w_addr + WA_W'(1);
            end
        end
    end

    assign out_first_in_ch = first_q;
    assign out_last_in_ch  = last_q;
    assign out_oc          = oc;
    assign out_w_addr      = w_addr;

endmodule
